// File: rtl/exp_sweep_ctrl.sv
// exp_sweep_ctrl: walks a combinational expression unit through every input
// vector, captures its response into a truth table and grades that table
// against a caller-supplied expected table (pass, first failing index,
// mismatch count). All outputs are registered.
module exp_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [2**N_IN-1:0]   expected_i,
    input  logic                 y_in_i,
    output logic [N_IN-1:0]      vec_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2**N_IN-1:0]   table_o,
    output logic                 pass_o,
    output logic [N_IN-1:0]      fail_idx_o,
    output logic [N_IN:0]        mismatch_cnt_o
);

    localparam int NVEC  = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]    MCNT_MAX = (N_IN+1)'(NVEC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NVEC-1:0]    tab_q, tab_d;
    logic               pass_q, pass_d;
    logic [N_IN-1:0]    fidx_q, fidx_d;
    logic [N_IN:0]      mcnt_q, mcnt_d;
    logic [NVEC-1:0]    exp_q, exp_d;

    logic               accept_w;
    logic               sample_w;
    logic               last_w;
    logic               miss_w;

    // Mismatch counter never wraps; it tops out at the number of vectors.
    function automatic logic [N_IN:0] mcnt_inc(input logic [N_IN:0] c);
        if (c == MCNT_MAX) begin
            return c;
        end
        return c + (N_IN+1)'(1);
    endfunction

    // Decode the events that steer both the FSM and the datapath.
    always_comb begin
        accept_w = (state_q == S_IDLE) && start_i && !abort_i;
        sample_w = (state_q == S_SWEEP) && !abort_i && (cnt_q == CNT_LAST);
        last_w   = sample_w && (vec_q == VEC_LAST);
        miss_w   = (y_in_i != exp_q[vec_q]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only from IDLE, abort only from SWEEP, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (last_w) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values; results hold unless a sweep starts, aborts or samples.
    always_comb begin
        cnt_d  = cnt_q;
        vec_d  = vec_q;
        tab_d  = tab_q;
        pass_d = pass_q;
        fidx_d = fidx_q;
        mcnt_d = mcnt_q;
        exp_d  = exp_q;
        busy_d = (state_d == S_SWEEP);
        done_d = (state_d == S_DONE);

        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                cnt_d = '0;
                if (accept_w) begin
                    exp_d  = expected_i;
                    tab_d  = '0;
                    pass_d = 1'b0;
                    fidx_d = '0;
                    mcnt_d = '0;
                end
            end
            S_SWEEP: begin
                if (abort_i) begin
                    vec_d  = '0;
                    cnt_d  = '0;
                    tab_d  = '0;
                    pass_d = 1'b0;
                    fidx_d = '0;
                    mcnt_d = '0;
                end else if (sample_w) begin
                    tab_d[vec_q] = y_in_i;
                    if (miss_w) begin
                        mcnt_d = mcnt_inc(mcnt_q);
                        if (mcnt_q == '0) begin
                            fidx_d = vec_q;
                        end
                    end
                    if (last_w) begin
                        // Grade on entry to DONE, including the final vector.
                        pass_d = (mcnt_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // vec is held through DONE and returns to 0 with IDLE.
                vec_d = '0;
                cnt_d = '0;
            end
            default: begin
                vec_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            vec_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tab_q  <= '0;
            pass_q <= 1'b0;
            fidx_q <= '0;
            mcnt_q <= '0;
            exp_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            vec_q  <= vec_d;
            busy_q <= busy_d;
            done_q <= done_d;
            tab_q  <= tab_d;
            pass_q <= pass_d;
            fidx_q <= fidx_d;
            mcnt_q <= mcnt_d;
            exp_q  <= exp_d;
        end
    end

    assign vec_o          = vec_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign table_o        = tab_q;
    assign pass_o         = pass_q;
    assign fail_idx_o     = fidx_q;
    assign mismatch_cnt_o = mcnt_q;

endmodule

// File: tb/tb_exp_sweep_ctrl.sv
// Bench for exp_sweep_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle by a behavioural model.
module tb_exp_sweep_ctrl;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int V      = 1 << N_IN;
    localparam int SWEEP_LEN = V * SETTLE;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [V-1:0]    expected = '0;
    logic [V-1:0]    f_cur = 8'hEA;
    logic            y_in;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic [V-1:0]    tbl;
    logic            pass;
    logic [N_IN-1:0] fail_idx;
    logic [N_IN:0]   mismatch_cnt;

    // Expression unit under control: a lookup of the current function table.
    assign y_in = f_cur[vec];

    exp_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .expected_i     (expected),
        .y_in_i         (y_in),
        .vec_o          (vec),
        .busy_o         (busy),
        .done_o         (done),
        .table_o        (tbl),
        .pass_o         (pass),
        .fail_idx_o     (fail_idx),
        .mismatch_cnt_o (mismatch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int e0 = 0;

    // Behavioural model: sweep progress expressed as edges since the accepted start.
    bit           m_run = 0;
    bit           m_done = 0;
    bit           m_pass = 0;
    int           m_k = 0;
    int           m_ns = 0;
    logic [V-1:0] m_f = '0;
    logic [V-1:0] m_exp = '0;

    function automatic void model_res(output logic [V-1:0] t, output int mc, output int fi);
        t = '0; mc = 0; fi = 0;
        for (int i = 0; i < m_ns; i++) begin
            t[i] = m_f[i];
            if (m_f[i] != m_exp[i]) begin
                if (mc == 0) fi = i;
                mc++;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    initial begin : model
        logic [V-1:0] t;
        int mc, fi, ve;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                m_run = 0; m_done = 0; m_pass = 0; m_k = 0; m_ns = 0;
                m_f = '0; m_exp = '0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_run) begin
                if (abort) begin
                    m_run = 0; m_ns = 0; m_pass = 0;
                end else begin
                    m_k++;
                    m_ns = m_k / SETTLE;
                    if (m_k == SWEEP_LEN) begin
                        m_run = 0; m_done = 1;
                        model_res(t, mc, fi);
                        m_pass = (mc == 0);
                    end
                end
            end else if (start && !abort) begin
                m_run = 1; m_k = 0; m_ns = 0; m_pass = 0;
                m_f = f_cur; m_exp = expected;
            end
            model_res(t, mc, fi);
            ve = m_run ? (m_k / SETTLE) : (m_done ? V - 1 : 0);
            n_cmp++;
            if (vec !== N_IN'(ve) || busy !== m_run || done !== m_done || tbl !== t ||
                pass !== m_pass || fail_idx !== N_IN'(fi) || mismatch_cnt !== (N_IN+1)'(mc)) begin
                n_bad++;
                $display("FAIL model cyc %0d: vec %0d/%0d busy %b/%b done %b/%b table %h/%h pass %b/%b fidx %0d/%0d mcnt %0d/%0d",
                         cyc, vec, ve, busy, m_run, done, m_done, tbl, t, pass, m_pass,
                         fail_idx, fi, mismatch_cnt, mc);
            end
        end
    end

    task automatic do_start(input logic [V-1:0] ex);
        @(negedge clk);
        expected = ex;
        start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done, required done within 200 cycles");
        end
    endtask

    task automatic wait_vec(input int v);
        bit seen;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (busy && vec == N_IN'(v)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL vec_timeout: got no vec %0d, required it within 100 cycles", v);
        end
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (!busy && !done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got busy %b done %b, required idle within 100 cycles", busy, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic sweep_check(input string nm, input logic [V-1:0] ex,
                               input logic p, input int fi, input int mc);
        int d;
        do_start(ex);
        wait_done(d);
        check({nm, "_latency"}, d - e0, SWEEP_LEN);
        check({nm, "_table"}, tbl, 8'hEA);
        check({nm, "_pass"}, pass, p);
        check({nm, "_fidx"}, fail_idx, fi);
        check({nm, "_mcnt"}, mismatch_cnt, mc);
        @(posedge clk); #1;
        check({nm, "_done_width"}, done, 0);
        check({nm, "_table_hold"}, tbl, 8'hEA);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d, d1, d2, d3, ndone;

        // Reset held with start high: nothing may start.
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; expected = 8'hEA; f_cur = 8'hEA;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_vec", vec, 0);
        check("rst_table", tbl, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_vec", vec, 0);

        // Clean and mismatching sweeps of y = a&b | c.
        sweep_check("clean", 8'hEA, 1'b1, 0, 0);
        sweep_check("miss1", 8'h6A, 1'b0, 7, 1);
        sweep_check("miss8", 8'h15, 1'b0, 0, 8);

        // Abort while vector 3 is driven.
        do_start(8'hEA);
        wait_vec(3);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_vec", vec, 0);
        check("abort_table", tbl, 0);
        @(negedge clk); abort = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        sweep_check("after_abort", 8'hEA, 1'b1, 0, 0);

        // Start pulsed mid-sweep leaves timing unchanged.
        do_start(8'hEA);
        repeat (5) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(d);
        check("midstart_latency", d - e0, SWEEP_LEN);

        // Start held high: back-to-back sweeps.
        wait_idle();
        @(negedge clk); start = 1'b1;
        wait_done(d1);
        wait_done(d2);
        wait_done(d3);
        check("held_period1", d2 - d1, SWEEP_LEN + 2);
        check("held_period2", d3 - d2, SWEEP_LEN + 2);
        @(negedge clk); start = 1'b0;
        wait_idle();

        // Abort together with start in IDLE is ignored.
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("startabort_busy", busy, 0);
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("startabort_idle", busy, 0);

        // Abort during DONE does not clear results.
        do_start(8'h6A);
        wait_done(d);
        check("abortdone_latency", d - e0, SWEEP_LEN);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        check("abortdone_done", done, 0);
        check("abortdone_table", tbl, 8'hEA);
        check("abortdone_mcnt", mismatch_cnt, 1);
        @(negedge clk); abort = 1'b0;

        // Asynchronous reset at vector 5, between edges.
        do_start(8'hEA);
        wait_vec(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_vec", vec, 0);
        check("async_busy", busy, 0);
        check("async_table", tbl, 0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("async_idle", busy, 0);
        sweep_check("after_reset", 8'hEA, 1'b1, 0, 0);

        // Randomized traffic; function table changes only while not sweeping.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (!busy) f_cur = V'($urandom);
            expected = V'($urandom);
            start = ($urandom_range(0, 4) == 0);
            abort = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk); start = 1'b0; abort = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
